// File: rtl/lvt_pkg.sv
// Shared definitions for the LVT memory read-side logic.
//   LVT_ADDR_W / LVT_DATA_W / LVT_WDATA_W : default widths of the 2W1R memory
//   fwd_sel_e   : which write port (if any) a same-cycle read must take its data from
//   hazard_sel  : resolves a same-cycle write/read address match, wr1 over wr0
package lvt_pkg;

  localparam int unsigned LVT_ADDR_W  = 7;
  localparam int unsigned LVT_DATA_W  = 7;
  localparam int unsigned LVT_WDATA_W = 5;

  typedef enum logic [1:0] {
    FwdNone,
    FwdWr0,
    FwdWr1
  } fwd_sel_e;

  // wr1 wins when both ports hit the same address, matching the LVT last-writer rule.
  function automatic fwd_sel_e hazard_sel(input logic wr0_hit, input logic wr1_hit);
    if (wr1_hit) return FwdWr1;
    if (wr0_hit) return FwdWr0;
    return FwdNone;
  endfunction

endpackage

// File: rtl/lvt_rsp_fifo.sv
// Response buffer: small in-order FIFO with a held output.
//   clk, rst   : clock, asynchronous active-low reset
//   push       : write push_data at the tail
//   push_data  : WIDTH-bit entry
//   pop        : remove head (ignored when empty)
//   count      : current number of entries
//   head       : head entry; when empty, the last popped value (0 after reset)
module lvt_rsp_fifo #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 7,
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CntW-1:0]  count,
  output logic [WIDTH-1:0] head
);

  localparam logic [CntW-1:0] Full    = CntW'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_pop;

  assign do_pop = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q];
    end
    case ({push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // Storage needs no reset: it is only observed through head while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;

  // The credit rule upstream must make a push into a full buffer impossible.
  no_overflow_a : assert property (@(posedge clk) disable iff (!rst) !(push && count_q == Full));

endmodule

// File: rtl/lvt_rd_port.sv
// Read-side front end of the 2W1R LVT memory.
//   req_valid/req_ready/req_addr : read request handshake
//   rsp_valid/rsp_ready/rsp_data : response handshake (data = buffer head)
//   mem_rd_en/mem_rd_addr        : memory read port, data returns one cycle later
//   mem_rd_data                  : memory read data
//   wr0_*/wr1_*                  : write ports, snooped for same-cycle forwarding
// A request is only accepted when a buffer slot is guaranteed for its response, so the
// buffer never overflows; RSP_DEPTH must be at least 3 to sustain one read per cycle.
module lvt_rd_port import lvt_pkg::*; #(
  parameter int unsigned ADDR_W    = LVT_ADDR_W,
  parameter int unsigned DATA_W    = LVT_DATA_W,
  parameter int unsigned WDATA_W   = LVT_WDATA_W,
  parameter int unsigned RSP_DEPTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [DATA_W-1:0]  mem_rd_data,
  input  logic               wr0_en,
  input  logic [ADDR_W-1:0]  wr0_addr,
  input  logic [WDATA_W-1:0] wr0_data,
  input  logic               wr1_en,
  input  logic [ADDR_W-1:0]  wr1_addr,
  input  logic [WDATA_W-1:0] wr1_data
);

  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
  localparam logic [CntW:0] Credits = (CntW + 1)'(RSP_DEPTH);

  logic               handshake;
  logic               inflight_q;
  logic               fwd_hit_q;
  logic [WDATA_W-1:0] fwd_data_q;
  fwd_sel_e           fwd_sel;
  logic [CntW-1:0]    count;
  logic [CntW:0]      occ;
  logic               push;
  logic [DATA_W-1:0]  push_data;
  logic               pop;

  // Occupancy counts the read still in the memory pipe, so req_ready never depends on
  // rsp_ready combinationally.
  assign occ       = {1'b0, count} + {{CntW{1'b0}}, inflight_q};
  assign req_ready = rst && (occ < Credits);
  assign handshake = req_valid && req_ready;

  assign mem_rd_en   = handshake;
  assign mem_rd_addr = req_addr;

  // Only writes in the issue cycle matter; later writes land after the memory read.
  assign fwd_sel = hazard_sel(wr0_en && (wr0_addr == req_addr),
                              wr1_en && (wr1_addr == req_addr));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      inflight_q <= handshake;
      if (handshake) begin
        fwd_hit_q  <= (fwd_sel != FwdNone);
        fwd_data_q <= (fwd_sel == FwdWr1) ? wr1_data : wr0_data;
      end
    end
  end

  assign push      = inflight_q;
  assign push_data = fwd_hit_q ? DATA_W'(fwd_data_q) : mem_rd_data;
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;

  lvt_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head      (rsp_data)
  );

endmodule

// File: tb/tb_lvt_rd_port.sv
module tb_lvt_rd_port;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [6:0] rsp_data;
  logic       mem_rd_en;
  logic [6:0] mem_rd_addr;
  logic [6:0] mem_rd_data;
  logic       wr0_en, wr1_en;
  logic [6:0] wr0_addr, wr1_addr;
  logic [4:0] wr0_data, wr1_data;

  always #5 clk = ~clk;

  lvt_rd_port dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .wr0_en      (wr0_en),
    .wr0_addr    (wr0_addr),
    .wr0_data    (wr0_data),
    .wr1_en      (wr1_en),
    .wr1_addr    (wr1_addr),
    .wr1_data    (wr1_data)
  );

  // Memory model: 1-cycle read latency, read returns pre-write contents.
  logic [6:0] mem [128];
  bit         mem_loaded;

  function automatic logic [6:0] init_val(int a);
    case (a)
      10: return 7'd5;
      20: return 7'd10;
      40: return 7'd20;
      70: return 7'd35;
      50: return 7'd0;
      default: return (a < 64) ? 7'((a * 5) + 3) : 7'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
      mem_loaded <= 1'b1;
    end else begin
      if (wr0_en) mem[wr0_addr] <= {2'b00, wr0_data};
      if (wr1_en) mem[wr1_addr] <= {2'b00, wr1_data};
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end
  end

  int         errors = 0;
  int         checks = 0;
  int         cyc_n = 0;
  int         npop = 0;
  int         first_pop_cyc = -1;
  int         last_pop_cyc = -1;
  logic [6:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] expected_for(logic [6:0] a);
    if (wr1_en && wr1_addr == a) return {2'b00, wr1_data};
    if (wr0_en && wr0_addr == a) return {2'b00, wr0_data};
    return mem[a];
  endfunction

  // Negedge sample: scoreboard push on request handshake, pop/compare on response.
  task automatic settle();
    logic [6:0] e;
    @(negedge clk);
    if (req_valid && req_ready) exp_q.push_back(expected_for(req_addr));
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_rsp", 32'(rsp_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_rsp_data", 32'(rsp_data), 32'(e));
      end
      npop++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc_n;
      last_pop_cyc = cyc_n;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) begin
      settle();
      tick();
    end
  endtask

  initial begin
    int acc;
    int p0;
    logic [6:0] ba [4];
    ba[0] = 7'd20; ba[1] = 7'd40; ba[2] = 7'd70; ba[3] = 7'd10;

    rst = 1'b0; req_valid = 1'b1; req_addr = 7'd10; rsp_ready = 1'b0;
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;

    // 1: reset
    tick(); tick();
    settle();
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_mem_rd_en", 32'(mem_rd_en), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    tick();
    req_valid = 1'b0; rst = 1'b1;
    settle();
    check("post_rst_req_ready", 32'(req_ready), 1);
    tick();

    // 2: basic read, latency 2
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 7'd10;
    settle();
    check("basic_mem_rd_en", 32'(mem_rd_en), 1);
    check("basic_mem_rd_addr", 32'(mem_rd_addr), 10);
    tick();
    req_valid = 1'b0;
    settle();
    check("basic_valid_T1", 32'(rsp_valid), 0);
    tick();
    settle();
    check("basic_valid_T2", 32'(rsp_valid), 1);
    check("basic_data_T2", 32'(rsp_data), 5);
    tick();
    settle();
    check("basic_empty_after_pop", 32'(rsp_valid), 0);
    check("basic_hold_last", 32'(rsp_data), 5);
    tick();

    // 3: forwarding, wr1 over wr0, then wr0 only; a write in T+1 must not leak in
    req_valid = 1'b1; req_addr = 7'd50;
    wr0_en = 1'b1; wr0_addr = 7'd50; wr0_data = 5'd25;
    wr1_en = 1'b1; wr1_addr = 7'd50; wr1_data = 5'd30;
    settle(); tick();
    req_valid = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0;
    settle(); tick();
    settle();
    check("fwd_wr1_data", 32'(rsp_data), 30);
    tick();
    req_valid = 1'b1; req_addr = 7'd50;
    wr0_en = 1'b1; wr0_addr = 7'd50; wr0_data = 5'd25;
    settle(); tick();
    req_valid = 1'b0; wr0_data = 5'd7;
    settle(); tick();
    wr0_en = 1'b0;
    settle();
    check("fwd_wr0_data", 32'(rsp_data), 25);
    tick();
    idle_cycles(2);

    // 4: back-pressure, credit limit of 3
    rsp_ready = 1'b0; acc = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_addr = ba[acc];
      settle();
      if (req_valid && req_ready) acc++;
      if (i == 4) check("bp_req_ready_low", 32'(req_ready), 0);
      tick();
    end
    req_valid = 1'b0;
    check("bp_accepted", 32'(acc), 3);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp_stall_valid", 32'(rsp_valid), 1);
      check("bp_stall_head0", 32'(rsp_data), 10);
      tick();
    end
    p0 = npop;
    rsp_ready = 1'b1;
    settle(); tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("bp_stall_head1", 32'(rsp_data), 20);
      tick();
    end
    rsp_ready = 1'b1;
    idle_cycles(4);
    check("bp_pop_count", 32'(npop - p0), 3);

    // 5: streaming 64 back-to-back reads
    p0 = npop; first_pop_cyc = -1;
    for (int i = 0; i < 64; i++) begin
      req_valid = 1'b1; req_addr = 7'(i);
      settle();
      if (!req_ready) check("stream_req_ready", 32'(req_ready), 1);
      tick();
    end
    req_valid = 1'b0;
    idle_cycles(4);
    check("stream_pop_count", 32'(npop - p0), 64);
    check("stream_consecutive", 32'(last_pop_cyc - first_pop_cyc), 63);
    check("stream_sb_empty", 32'(exp_q.size()), 0);

    // 6: reset with two buffered and one in flight
    rsp_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      req_valid = 1'b1; req_addr = 7'(i);
      settle(); tick();
    end
    req_valid = 1'b0;
    check("mid_pre_rst_valid", 32'(rsp_valid), 1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_req_ready", 32'(req_ready), 0);
    exp_q.delete();
    tick(); tick();
    rst = 1'b1;
    p0 = npop;
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 7'd95;
    settle(); tick();
    req_valid = 1'b0;
    idle_cycles(5);
    check("mid_post_pop_count", 32'(npop - p0), 1);
    check("mid_post_data", 32'(rsp_data), 0);
    check("mid_sb_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
